// File: rtl/lsu_pkg.sv
// Shared types and encodings for the load/store unit.
package lsu_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRmwRd,
    StWrite,
    StFault
  } lsu_state_e;

  localparam logic [1:0] LSU_SZ_B   = 2'b00;
  localparam logic [1:0] LSU_SZ_H   = 2'b01;
  localparam logic [1:0] LSU_SZ_W   = 2'b10;
  localparam logic [1:0] LSU_SZ_RSV = 2'b11;

  // Access width in bytes; the reserved encoding is sized as a word, it faults anyway.
  function automatic logic [2:0] lsu_size_bytes(input logic [1:0] size);
    unique case (size)
      LSU_SZ_B: lsu_size_bytes = 3'd1;
      LSU_SZ_H: lsu_size_bytes = 3'd2;
      default:  lsu_size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte/halfword lane handling: extract+extend for loads, lane merge for stores.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  offset_i,
  input  logic        signed_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merged_o
);

  logic [31:0] shifted;
  logic [31:0] lane_mask;
  logic [31:0] wdata_sh;

  // Shift the addressed lane down and extend it to 32 bits.
  always_comb begin
    shifted     = word_i >> {offset_i, 3'b000};
    load_data_o = word_i;
    case (size_i)
      LSU_SZ_B: load_data_o = {{24{signed_i & shifted[7]}}, shifted[7:0]};
      LSU_SZ_H: load_data_o = {{16{signed_i & shifted[15]}}, shifted[15:0]};
      default:  load_data_o = word_i;
    endcase
  end

  // Replace the addressed lane of the old word with the right-aligned store data.
  always_comb begin
    lane_mask = 32'hFFFF_FFFF;
    case (size_i)
      LSU_SZ_B: lane_mask = 32'h0000_00FF << {offset_i, 3'b000};
      LSU_SZ_H: lane_mask = 32'h0000_FFFF << {offset_i, 3'b000};
      default:  lane_mask = 32'hFFFF_FFFF;
    endcase
    wdata_sh = wdata_i << {offset_i, 3'b000};
    merged_o = (word_i & ~lane_mask) | (wdata_sh & lane_mask);
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator between the MEM stage and the byte-addressed data memory.
// Sub-word (byte/half) accesses are built only when LSU_SUBWORD_EN is defined;
// otherwise those sizes fault like the reserved size.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 128
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_signed_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_fault_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_wr_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  input  logic [31:0] mem_data_rd_i
);

  lsu_state_e  state_q;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic        signed_q;
  logic [31:0] wdata_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_data_wr_q;
  logic        mem_read_q;
  logic        mem_write_q;
  logic        resp_valid_q;
  logic        resp_fault_q;
  logic [31:0] resp_rdata_q;

  logic        req_fire;
  logic        req_fault;
  logic [32:0] req_end;
  logic [31:0] load_data;

  assign req_ready_o = (state_q == StIdle) && !rst_i;
  assign req_fire    = req_valid_i && req_ready_o;

  // Fault decode of the incoming request: bad size, misalignment or out of range.
  always_comb begin
    // 33 bits so a huge address cannot wrap past the range check
    req_end   = {1'b0, req_addr_i} + {30'b0, lsu_size_bytes(req_size_i)};
    req_fault = 1'b0;
    case (req_size_i)
`ifdef LSU_SUBWORD_EN
      LSU_SZ_B: req_fault = 1'b0;
      LSU_SZ_H: req_fault = req_addr_i[0];
`else
      LSU_SZ_B, LSU_SZ_H: req_fault = 1'b1;
`endif
      LSU_SZ_W: req_fault = |req_addr_i[1:0];
      default:  req_fault = 1'b1;
    endcase
    if (req_end > 33'(MEM_BYTES)) begin
      req_fault = 1'b1;
    end
  end

`ifdef LSU_SUBWORD_EN
  logic [31:0] merged;

  lsu_lane_align u_lane_align (
    .size_i      (size_q),
    .offset_i    (off_q),
    .signed_i    (signed_q),
    .word_i      (mem_data_rd_i),
    .wdata_i     (wdata_q),
    .load_data_o (load_data),
    .merged_o    (merged)
  );
`else
  logic unused_subword;
  assign unused_subword = ^{size_q, off_q, signed_q, wdata_q};
  assign load_data      = mem_data_rd_i;
`endif

  // Request FSM; memory strobes and response are registered on state entry/exit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      size_q        <= LSU_SZ_B;
      off_q         <= 2'b00;
      signed_q      <= 1'b0;
      wdata_q       <= '0;
      mem_addr_q    <= '0;
      mem_data_wr_q <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_fault_q  <= 1'b0;
      resp_rdata_q  <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
      resp_rdata_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (req_fire) begin
            size_q   <= req_size_i;
            off_q    <= req_addr_i[1:0];
            signed_q <= req_signed_i;
            wdata_q  <= req_wdata_i;
            if (req_fault) begin
              state_q <= StFault;
            end else if (!req_we_i) begin
              state_q    <= StLoad;
              mem_read_q <= 1'b1;
              mem_addr_q <= {req_addr_i[31:2], 2'b00};
`ifdef LSU_SUBWORD_EN
            end else if (req_size_i != LSU_SZ_W) begin
              state_q    <= StRmwRd;
              mem_read_q <= 1'b1;
              mem_addr_q <= {req_addr_i[31:2], 2'b00};
`endif
            end else begin
              state_q       <= StWrite;
              mem_write_q   <= 1'b1;
              mem_addr_q    <= {req_addr_i[31:2], 2'b00};
              mem_data_wr_q <= req_wdata_i;
            end
          end
        end
        StLoad: begin
          state_q      <= StIdle;
          resp_valid_q <= 1'b1;
          resp_rdata_q <= load_data;
          mem_read_q   <= 1'b0;
          mem_addr_q   <= '0;
        end
`ifdef LSU_SUBWORD_EN
        StRmwRd: begin
          state_q       <= StWrite;
          mem_read_q    <= 1'b0;
          mem_write_q   <= 1'b1;
          mem_data_wr_q <= merged;
        end
`endif
        StWrite: begin
          state_q       <= StIdle;
          resp_valid_q  <= 1'b1;
          mem_write_q   <= 1'b0;
          mem_addr_q    <= '0;
          mem_data_wr_q <= '0;
        end
        StFault: begin
          state_q      <= StIdle;
          resp_valid_q <= 1'b1;
          resp_fault_q <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Reset in the strobe cycle must suppress the memory access immediately.
  assign mem_read_o    = mem_read_q & ~rst_i;
  assign mem_write_o   = mem_write_q & ~rst_i;
  assign mem_addr_o    = mem_addr_q;
  assign mem_data_wr_o = mem_data_wr_q;
  assign resp_valid_o  = resp_valid_q;
  assign resp_fault_o  = resp_fault_q;
  assign resp_rdata_o  = resp_rdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed table, corner sequences, random vs model.
module tb_lsu_mem_ctrl;

  localparam int unsigned MEM_BYTES = 128;
`ifdef LSU_SUBWORD_EN
  localparam bit SubwordEn = 1'b1;
`else
  localparam bit SubwordEn = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [1:0]  req_size_i = 2'b00;
  logic        req_signed_i = 1'b0;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        resp_fault_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_wr_o;
  logic        mem_read_o;
  logic        mem_write_o;
  logic [31:0] mem_data_rd_i;

  int n_tests = 0;
  int n_fail  = 0;

  lsu_mem_ctrl #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_we_i      (req_we_i),
    .req_size_i    (req_size_i),
    .req_signed_i  (req_signed_i),
    .req_addr_i    (req_addr_i),
    .req_wdata_i   (req_wdata_i),
    .resp_valid_o  (resp_valid_o),
    .resp_rdata_o  (resp_rdata_o),
    .resp_fault_o  (resp_fault_o),
    .mem_addr_o    (mem_addr_o),
    .mem_data_wr_o (mem_data_wr_o),
    .mem_read_o    (mem_read_o),
    .mem_write_o   (mem_write_o),
    .mem_data_rd_i (mem_data_rd_i)
  );

  always #5 clk_i = ~clk_i;

  // Data memory seen by the DUT: combinational read, write committed at posedge.
  logic [7:0] mem [MEM_BYTES];
  logic       mem_clr = 1'b1;
  logic [6:0] ra;
  assign ra = mem_addr_o[6:0];
  assign mem_data_rd_i = (mem_addr_o < MEM_BYTES) ?
      {mem[ra + 7'd3], mem[ra + 7'd2], mem[ra + 7'd1], mem[ra]} : 32'h0;

  always @(posedge clk_i) begin
    if (mem_clr) begin
      for (int i = 0; i < int'(MEM_BYTES); i++) mem[i] <= 8'h00;
    end else if (mem_write_o && mem_addr_o < MEM_BYTES) begin
      mem[ra]         <= mem_data_wr_o[7:0];
      mem[ra + 7'd1]  <= mem_data_wr_o[15:8];
      mem[ra + 7'd2]  <= mem_data_wr_o[23:16];
      mem[ra + 7'd3]  <= mem_data_wr_o[31:24];
    end
  end

  // Reference memory image, updated only by the model.
  logic [7:0] ref_mem [MEM_BYTES];

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  // Behavioural model: byte-array memory with size/alignment/range rules.
  task automatic model(input logic we, input logic [1:0] sz, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output logic f, output logic [31:0] rd, output int lat);
    int n;
    longint unsigned a;
    n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    a  = longint'(addr);
    f  = (sz == 2'b11) || (!SubwordEn && sz != 2'b10) || (a % n != 0) ||
         (a + longint'(n) > longint'(MEM_BYTES));
    rd  = '0;
    lat = 2;
    if (!f) begin
      if (we) begin
        for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
        lat = (n == 4) ? 2 : 3;
      end else begin
        for (int i = 0; i < n; i++) rd[8*i +: 8] = ref_mem[int'(a) + i];
        if (sgn && rd[8*n-1]) begin
          for (int j = 8 * n; j < 32; j++) rd[j] = 1'b1;
        end
      end
    end
  endtask

  // Issue one request at a negedge with the DUT idle; return at the response negedge.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic f, output logic [31:0] rd, output int lat,
                        output logic rd_seen, output logic wr_seen, output int wr_cyc,
                        output logic [31:0] wr_addr);
    req_valid_i  = 1'b1;
    req_we_i     = we;
    req_size_i   = sz;
    req_signed_i = sgn;
    req_addr_i   = addr;
    req_wdata_i  = wd;
    check32("req_ready_before_accept", {31'b0, req_ready_o}, 32'd1);
    @(posedge clk_i);
    #1;
    req_valid_i  = 1'b0;
    req_we_i     = 1'($urandom);
    req_size_i   = 2'($urandom);
    req_signed_i = 1'($urandom);
    req_addr_i   = $urandom;
    req_wdata_i  = $urandom;
    f = 1'b0; rd = '0; lat = 0; rd_seen = 1'b0; wr_seen = 1'b0; wr_cyc = 0; wr_addr = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk_i);
      if (mem_read_o) rd_seen = 1'b1;
      if (mem_write_o) begin
        wr_seen = 1'b1;
        wr_cyc  = k;
        wr_addr = mem_addr_o;
      end
      if (resp_valid_o) begin
        f   = resp_fault_o;
        rd  = resp_rdata_o;
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_and_check(input string tag, input logic we, input logic [1:0] sz,
                               input logic sgn, input logic [31:0] addr, input logic [31:0] wd,
                               input logic ef, input logic [31:0] er, input int el);
    logic f, rd_seen, wr_seen;
    logic [31:0] rd, wr_addr;
    int lat, wr_cyc;
    do_req(we, sz, sgn, addr, wd, f, rd, lat, rd_seen, wr_seen, wr_cyc, wr_addr);
    check32({tag, "_fault"}, {31'b0, f}, {31'b0, ef});
    check32({tag, "_rdata"}, rd, er);
    check32({tag, "_latency"}, 32'(lat), 32'(el));
    if (ef) begin
      check32({tag, "_no_mem_access"}, {31'b0, rd_seen | wr_seen}, 32'd0);
    end else if (we) begin
      check32({tag, "_write_seen"}, {31'b0, wr_seen}, 32'd1);
      check32({tag, "_write_cycle"}, 32'(wr_cyc), 32'(el - 1));
      check32({tag, "_write_addr"}, wr_addr, {addr[31:2], 2'b00});
    end else begin
      check32({tag, "_read_seen"}, {31'b0, rd_seen}, 32'd1);
      check32({tag, "_no_write"}, {31'b0, wr_seen}, 32'd0);
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        ef;   // expectations with sub-word support
    logic [31:0] er;
    int          el;
    logic        nf;   // expectations for the word-only build
    logic [31:0] nr;
    int          nl;
  } vec_t;

  vec_t tbl [17];

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic        mf;
    logic [31:0] mr, e1, e2, old_word;
    int          ml;
    logic        sel_f;
    logic [31:0] sel_r;
    int          sel_l;

    for (int i = 0; i < int'(MEM_BYTES); i++) ref_mem[i] = 8'h00;

    tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0,        2, 1'b0, 32'h0,        2};
    tbl[1]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF, 2, 1'b0, 32'hDEADBEEF, 2};
    tbl[2]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, 1'b0, 32'h0,        2, 1'b0, 32'h0,        2};
    tbl[3]  = '{1'b1, 2'd0, 1'b0, 32'h11, 32'h123456AA, 1'b0, 32'h0,        3, 1'b1, 32'h0,        2};
    tbl[4]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        1'b0, 32'h1122AA44, 2, 1'b0, 32'h11223344, 2};
    tbl[5]  = '{1'b0, 2'd0, 1'b1, 32'h11, 32'h0,        1'b0, 32'hFFFFFFAA, 2, 1'b1, 32'h0,        2};
    tbl[6]  = '{1'b0, 2'd0, 1'b0, 32'h11, 32'h0,        1'b0, 32'h000000AA, 2, 1'b1, 32'h0,        2};
    tbl[7]  = '{1'b0, 2'd1, 1'b1, 32'h12, 32'h0,        1'b0, 32'h00001122, 2, 1'b1, 32'h0,        2};
    tbl[8]  = '{1'b0, 2'd1, 1'b0, 32'h13, 32'h0,        1'b1, 32'h0,        2, 1'b1, 32'h0,        2};
    tbl[9]  = '{1'b1, 2'd2, 1'b0, 32'h7E, 32'hFFFFFFFF, 1'b1, 32'h0,        2, 1'b1, 32'h0,        2};
    tbl[10] = '{1'b0, 2'd2, 1'b0, 32'h80, 32'h0,        1'b1, 32'h0,        2, 1'b1, 32'h0,        2};
    tbl[11] = '{1'b1, 2'd1, 1'b0, 32'h7E, 32'h5555BEEF, 1'b0, 32'h0,        3, 1'b1, 32'h0,        2};
    tbl[12] = '{1'b0, 2'd2, 1'b0, 32'h7C, 32'h0,        1'b0, 32'hBEEF0000, 2, 1'b0, 32'h0,        2};
    tbl[13] = '{1'b0, 2'd1, 1'b1, 32'h7E, 32'h0,        1'b0, 32'hFFFFBEEF, 2, 1'b1, 32'h0,        2};
    tbl[14] = '{1'b0, 2'd0, 1'b0, 32'h7F, 32'h0,        1'b0, 32'h000000BE, 2, 1'b1, 32'h0,        2};
    tbl[15] = '{1'b0, 2'd3, 1'b0, 32'h00, 32'h0,        1'b1, 32'h0,        2, 1'b1, 32'h0,        2};
    tbl[16] = '{1'b1, 2'd0, 1'b0, 32'h80, 32'h0,        1'b1, 32'h0,        2, 1'b1, 32'h0,        2};

    // Reset
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check32("reset_ready_low_in_reset", {31'b0, req_ready_o}, 32'd0);
    check32("reset_mem_write_gated", {31'b0, mem_write_o}, 32'd0);
    rst_i   = 1'b0;
    mem_clr = 1'b0;
    @(negedge clk_i);
    check32("reset_ready", {31'b0, req_ready_o}, 32'd1);
    check32("reset_resp_valid", {31'b0, resp_valid_o}, 32'd0);
    check32("reset_resp_rdata", resp_rdata_o, 32'd0);
    check32("reset_resp_fault", {31'b0, resp_fault_o}, 32'd0);
    check32("reset_mem_strobes", {30'b0, mem_read_o, mem_write_o}, 32'd0);
    check32("reset_mem_addr", mem_addr_o, 32'd0);
    check32("reset_mem_data_wr", mem_data_wr_o, 32'd0);

    // Directed table
    for (int i = 0; i < 17; i++) begin
      sel_f = SubwordEn ? tbl[i].ef : tbl[i].nf;
      sel_r = SubwordEn ? tbl[i].er : tbl[i].nr;
      sel_l = SubwordEn ? tbl[i].el : tbl[i].nl;
      model(tbl[i].we, tbl[i].sz, tbl[i].sgn, tbl[i].addr, tbl[i].wd, mf, mr, ml);
      run_and_check($sformatf("row%0d", i), tbl[i].we, tbl[i].sz, tbl[i].sgn, tbl[i].addr,
                    tbl[i].wd, sel_f, sel_r, sel_l);
    end

    // Reset during the WRITE cycle of a word store to 0x20
    old_word = {ref_mem[8'h23], ref_mem[8'h22], ref_mem[8'h21], ref_mem[8'h20]};
    req_valid_i = 1'b1; req_we_i = 1'b1; req_size_i = 2'd2; req_signed_i = 1'b0;
    req_addr_i  = 32'h20; req_wdata_i = 32'hCAFEF00D;
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    rst_i       = 1'b1;
    @(negedge clk_i);
    check32("rstwr_mem_write_suppressed", {31'b0, mem_write_o}, 32'd0);
    check32("rstwr_no_resp_a", {31'b0, resp_valid_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    check32("rstwr_no_resp_b", {31'b0, resp_valid_o}, 32'd0);
    @(negedge clk_i);
    check32("rstwr_ready_after_reset", {31'b0, req_ready_o}, 32'd1);
    check32("rstwr_no_resp_c", {31'b0, resp_valid_o}, 32'd0);
    check32("rstwr_mem_unchanged", {mem[8'h23], mem[8'h22], mem[8'h21], mem[8'h20]}, old_word);

    // Back-to-back word loads with req_valid_i held high
    model(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, mf, e1, ml);
    model(1'b0, 2'd2, 1'b0, 32'h7C, 32'h0, mf, e2, ml);
    req_valid_i = 1'b1; req_we_i = 1'b0; req_size_i = 2'd2; req_signed_i = 1'b0;
    req_addr_i  = 32'h10;
    check32("b2b_ready_first", {31'b0, req_ready_o}, 32'd1);
    @(posedge clk_i);
    #1;
    req_addr_i = 32'h7C;
    @(negedge clk_i);
    check32("b2b_busy_not_ready", {31'b0, req_ready_o}, 32'd0);
    check32("b2b_no_early_resp", {31'b0, resp_valid_o}, 32'd0);
    @(negedge clk_i);
    check32("b2b_resp1_valid", {31'b0, resp_valid_o}, 32'd1);
    check32("b2b_resp1_rdata", resp_rdata_o, e1);
    check32("b2b_ready_with_resp", {31'b0, req_ready_o}, 32'd1);
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    @(negedge clk_i);
    check32("b2b_resp_gap", {31'b0, resp_valid_o}, 32'd0);
    @(negedge clk_i);
    check32("b2b_resp2_valid", {31'b0, resp_valid_o}, 32'd1);
    check32("b2b_resp2_rdata", resp_rdata_o, e2);

    // Random requests against the model
    for (int i = 0; i < 300; i++) begin
      logic        rwe, rsgn;
      logic [1:0]  rsz;
      logic [31:0] raddr, rwd;
      rwe  = 1'($urandom);
      rsz  = 2'($urandom);
      rsgn = 1'($urandom);
      rwd  = $urandom;
      if ($urandom_range(0, 15) == 0) raddr = $urandom;
      else raddr = 32'($urandom_range(0, 135));
      if ($urandom_range(0, 1) == 1) begin
        raddr = (rsz == 2'd1) ? {raddr[31:1], 1'b0} : (rsz >= 2'd2) ? {raddr[31:2], 2'b00} : raddr;
      end
      model(rwe, rsz, rsgn, raddr, rwd, mf, mr, ml);
      run_and_check($sformatf("rand%0d", i), rwe, rsz, rsgn, raddr, rwd, mf, mr, ml);
    end

    // Final memory image must match the model's
    begin
      int diffs;
      diffs = 0;
      for (int i = 0; i < int'(MEM_BYTES); i++) if (mem[i] !== ref_mem[i]) diffs++;
      check32("final_mem_image_diff_bytes", 32'(diffs), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
